// File: rtl/dwt97_pkg.sv
// -----------------------------------------------------------------------------
// dwt97_pkg
// Shared types for the 9/7 DWT band serializer.
//   band_e        : subband code carried on m_band_o (LL/HL/LH/HH)
//   ser_state_e   : serializer FSM state (EMPTY/LOW/HIGH)
//   band_of()     : builds the band code from line parity and low/high word
// -----------------------------------------------------------------------------
package dwt97_pkg;

    typedef enum logic [1:0] {
        LL = 2'd0,
        HL = 2'd1,
        LH = 2'd2,
        HH = 2'd3
    } band_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOW   = 2'd1,
        HIGH  = 2'd2
    } ser_state_e;

    // Vertical parity selects the row pair (L*/H*), the word selects the column.
    function automatic band_e band_of(input logic i_parity, input logic i_is_high);
        return band_e'({i_parity, i_is_high});
    endfunction

endpackage

// File: rtl/dwt97_band_coord_counter.sv
// -----------------------------------------------------------------------------
// dwt97_band_coord_counter
// Tracks the (x, y) position within a subband and the vertical line parity of
// the incoming beat stream, plus a sticky overflow flag for over-long lines.
// The o_x/o_y/o_parity outputs are the tags for the beat being accepted this
// cycle (sof already applied); the registers advance on i_accept.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_accept        : a beat is accepted this cycle
//   i_sof, i_eol    : that beat starts a frame / ends a line
//   o_x, o_y        : coordinate tags for the current beat
//   o_parity        : 0 = vertical-low line, 1 = vertical-high line
//   o_overflow      : sticky, line exceeded MaximumSideSize/2 beats
// -----------------------------------------------------------------------------
module dwt97_band_coord_counter #(
    parameter int MaximumSideSize = 512,
    parameter int CoordWidth      = $clog2(MaximumSideSize / 2)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_accept,
    input  logic                  i_sof,
    input  logic                  i_eol,
    output logic [CoordWidth-1:0] o_x,
    output logic [CoordWidth-1:0] o_y,
    output logic                  o_parity,
    output logic                  o_overflow
);

    localparam logic [CoordWidth-1:0] LastCoord = CoordWidth'(MaximumSideSize / 2 - 1);

    logic [CoordWidth-1:0] r_x;
    logic [CoordWidth-1:0] r_y;
    logic                  r_parity;
    logic                  r_overflow;

    // A frame start overrides whatever the counters hold, for this very beat.
    logic [CoordWidth-1:0] w_x;
    logic [CoordWidth-1:0] w_y;
    logic                  w_parity;

    assign w_x      = i_sof ? '0   : r_x;
    assign w_y      = i_sof ? '0   : r_y;
    assign w_parity = i_sof ? 1'b0 : r_parity;

    assign o_x        = w_x;
    assign o_y        = w_y;
    assign o_parity   = w_parity;
    assign o_overflow = r_overflow;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; later assignments in the block override earlier ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_parity   <= 1'b0;
            r_overflow <= 1'b0;
        end else if (i_accept) begin
            r_overflow <= i_sof ? 1'b0 : r_overflow;
            if (i_eol) begin
                r_x      <= '0;
                r_parity <= ~w_parity;
                // y advances once per LL/HL + LH/HH line pair, i.e. after HH.
                if (w_parity) begin
                    r_y <= (w_y == LastCoord) ? '0 : w_y + CoordWidth'(1);
                end else begin
                    r_y <= w_y;
                end
            end else begin
                r_parity <= w_parity;
                r_y      <= w_y;
                if (w_x == LastCoord) begin
                    r_x        <= w_x;
                    r_overflow <= 1'b1;
                end else begin
                    r_x <= w_x + CoordWidth'(1);
                end
            end
        end
    end

endmodule

// File: rtl/dwt97_band_serializer.sv
// -----------------------------------------------------------------------------
// dwt97_band_serializer
// Serialises {high, low} coefficient beats from the column DWT stage into one
// coefficient per beat, each tagged with subband and in-band (x, y).
//   clk_i, rst_i             : clock, synchronous active-high reset
//   s_valid_i / s_ready_o    : input handshake
//   s_sof_i, s_eol_i         : frame start / line end markers of the beat
//   s_data_i                 : {high, low} coefficient pair
//   m_valid_o / m_ready_i    : output handshake
//   m_sof_o, m_eol_o         : frame start (low word) / line end (high word)
//   m_band_o, m_x_o, m_y_o   : subband code and position within the band
//   m_data_o                 : coefficient
//   overflow_o               : sticky over-long line flag
// -----------------------------------------------------------------------------
module dwt97_band_serializer
    import dwt97_pkg::*;
#(
    parameter  int DataWidth       = 16,
    parameter  int MaximumSideSize = 512,
    localparam int CoordWidth      = $clog2(MaximumSideSize / 2)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   s_ready_o,
    input  logic                   s_valid_i,
    input  logic                   s_sof_i,
    input  logic                   s_eol_i,
    input  logic [2*DataWidth-1:0] s_data_i,
    input  logic                   m_ready_i,
    output logic                   m_valid_o,
    output logic                   m_sof_o,
    output logic                   m_eol_o,
    output logic [1:0]             m_band_o,
    output logic [CoordWidth-1:0]  m_x_o,
    output logic [CoordWidth-1:0]  m_y_o,
    output logic [DataWidth-1:0]   m_data_o,
    output logic                   overflow_o
);

    ser_state_e             r_state;
    logic                   r_valid;
    logic                   r_sof;
    logic                   r_eol;
    logic [1:0]             r_band;
    logic [CoordWidth-1:0]  r_x;
    logic [CoordWidth-1:0]  r_y;
    logic [DataWidth-1:0]   r_data;
    logic [DataWidth-1:0]   r_hold;
    logic                   r_hold_eol;

    logic                   w_accept;
    logic [CoordWidth-1:0]  w_x;
    logic [CoordWidth-1:0]  w_y;
    logic                   w_parity;

    // The only combinational input-to-output path: a new beat may enter in the
    // same cycle the high word leaves.
    assign s_ready_o = (r_state == EMPTY) | ((r_state == HIGH) & m_ready_i);
    assign w_accept  = s_valid_i & s_ready_o;

    dwt97_band_coord_counter #(
        .MaximumSideSize (MaximumSideSize),
        .CoordWidth      (CoordWidth)
    ) u_coord (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_accept   (w_accept),
        .i_sof      (s_sof_i),
        .i_eol      (s_eol_i),
        .o_x        (w_x),
        .o_y        (w_y),
        .o_parity   (w_parity),
        .o_overflow (overflow_o)
    );

    // Accept is only possible from EMPTY or from HIGH while the high word is
    // taken, so it always lands in LOW with the new low word presented.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= EMPTY;
            r_valid    <= 1'b0;
            r_sof      <= 1'b0;
            r_eol      <= 1'b0;
            r_band     <= 2'd0;
            r_x        <= '0;
            r_y        <= '0;
            r_data     <= '0;
            r_hold_eol <= 1'b0;
        end else if (w_accept) begin
            r_state    <= LOW;
            r_valid    <= 1'b1;
            r_data     <= s_data_i[DataWidth-1:0];
            r_band     <= band_of(w_parity, 1'b0);
            r_x        <= w_x;
            r_y        <= w_y;
            r_sof      <= s_sof_i;
            r_eol      <= 1'b0;
            r_hold_eol <= s_eol_i;
        end else if (m_ready_i) begin
            case (r_state)
                LOW: begin
                    r_state <= HIGH;
                    r_data  <= r_hold;
                    r_band  <= band_of(r_band[1], 1'b1);
                    r_sof   <= 1'b0;
                    r_eol   <= r_hold_eol;
                end
                HIGH: begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                    r_sof   <= 1'b0;
                    r_eol   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // NOTE: the side register is pure data qualified by r_state, so it carries
    // no reset; a discarded word can never reach m_data_o.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_hold <= s_data_i[2*DataWidth-1:DataWidth];
        end
    end

    assign m_valid_o = r_valid;
    assign m_sof_o   = r_sof;
    assign m_eol_o   = r_eol;
    assign m_band_o  = r_band;
    assign m_x_o     = r_x;
    assign m_y_o     = r_y;
    assign m_data_o  = r_data;

endmodule

// File: tb/tb_dwt97_band_serializer.sv
// -----------------------------------------------------------------------------
// tb_dwt97_band_serializer
// Self-checking bench: directed table vectors, hand-written corner sequences
// and a randomized stream scored against a queue-based coefficient model.
// -----------------------------------------------------------------------------
module tb_dwt97_band_serializer;

    localparam int DW   = 16;
    localparam int MSS  = 8;
    localparam int CW   = $clog2(MSS / 2);
    localparam int HALF = MSS / 2;

    logic            clk_i;
    logic            rst_i;
    logic            s_ready_o;
    logic            s_valid_i;
    logic            s_sof_i;
    logic            s_eol_i;
    logic [2*DW-1:0] s_data_i;
    logic            m_ready_i;
    logic            m_valid_o;
    logic            m_sof_o;
    logic            m_eol_o;
    logic [1:0]      m_band_o;
    logic [CW-1:0]   m_x_o;
    logic [CW-1:0]   m_y_o;
    logic [DW-1:0]   m_data_o;
    logic            overflow_o;

    dwt97_band_serializer #(
        .DataWidth       (DW),
        .MaximumSideSize (MSS)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .s_ready_o  (s_ready_o),
        .s_valid_i  (s_valid_i),
        .s_sof_i    (s_sof_i),
        .s_eol_i    (s_eol_i),
        .s_data_i   (s_data_i),
        .m_ready_i  (m_ready_i),
        .m_valid_o  (m_valid_o),
        .m_sof_o    (m_sof_o),
        .m_eol_o    (m_eol_o),
        .m_band_o   (m_band_o),
        .m_x_o      (m_x_o),
        .m_y_o      (m_y_o),
        .m_data_o   (m_data_o),
        .overflow_o (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    band;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          sof;
        logic          eol;
        int            cyc;
    } coef_t;

    typedef struct {
        bit            sof;
        bit            eol;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic [1:0]    band_lo;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } vec_t;

    coef_t exp_q[$];
    coef_t log_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    int    rdy_mode = 0;
    int    rdy_idx  = 0;

    // Reference model state: position of the next beat in the frame.
    int    mx, my, mpar;
    bit    movf;

    vec_t  tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input coef_t c);
        return 32'({c.sof, c.eol, c.band, c.x, c.y, c.data});
    endfunction

    function automatic coef_t mk(input logic [DW-1:0] d, input logic [1:0] b,
                                 input logic [CW-1:0] x, input logic [CW-1:0] y,
                                 input logic sof, input logic eol);
        coef_t c;
        c.data = d; c.band = b; c.x = x; c.y = y; c.sof = sof; c.eol = eol; c.cyc = 0;
        return c;
    endfunction

    function automatic void model_reset();
        mx = 0; my = 0; mpar = 0; movf = 1'b0;
    endfunction

    // One input beat becomes two tagged coefficients; then the position advances.
    function automatic void model_beat(input bit sof, input bit eol,
                                       input logic [DW-1:0] hi, input logic [DW-1:0] lo);
        if (sof) begin
            mx = 0; my = 0; mpar = 0; movf = 1'b0;
        end
        exp_q.push_back(mk(lo, 2'(mpar * 2),     CW'(mx), CW'(my), sof,  1'b0));
        exp_q.push_back(mk(hi, 2'(mpar * 2 + 1), CW'(mx), CW'(my), 1'b0, eol));
        if (eol) begin
            mx = 0;
            if (mpar == 1) my = (my + 1) % HALF;
            mpar = 1 - mpar;
        end else if (mx == HALF - 1) begin
            movf = 1'b1;
        end else begin
            mx = mx + 1;
        end
    endfunction

    always @(posedge clk_i) cyc++;

    always @(posedge clk_i) begin
        #1;
        rdy_idx++;
        case (rdy_mode)
            0:       m_ready_i = 1'b1;
            1:       m_ready_i = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
            2:       m_ready_i = 1'($urandom_range(0, 1));
            default: m_ready_i = 1'b0;
        endcase
    end

    // Output monitor: scoreboard compare, log, and stall stability.
    coef_t mon_cur, mon_exp, stall_c;
    bit    stall_prev = 1'b0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            stall_prev = 1'b0;
        end else begin
            mon_cur = mk(m_data_o, m_band_o, m_x_o, m_y_o, m_sof_o, m_eol_o);
            mon_cur.cyc = cyc;
            if (stall_prev) check("stall_hold", pack(mon_cur), pack(stall_c));
            if (m_valid_o && m_ready_i) begin
                log_q.push_back(mon_cur);
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("sb_out", pack(mon_cur), pack(mon_exp));
                end
            end
            stall_prev = m_valid_o && !m_ready_i;
            stall_c    = mon_cur;
        end
    end

    task automatic drive_beat(input bit sof, input bit eol,
                              input logic [DW-1:0] hi, input logic [DW-1:0] lo);
        s_valid_i = 1'b1;
        s_sof_i   = sof;
        s_eol_i   = eol;
        s_data_i  = {hi, lo};
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_i);
            if (s_ready_o) begin
                model_beat(sof, eol, hi, lo);
                @(posedge clk_i);
                #1;
                return;
            end
        end
        check("accept_timeout", 32'd0, 32'd1);
        s_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid_i = 1'b0;
        s_sof_i   = 1'b0;
        s_eol_i   = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic drain();
        rdy_mode  = 0;
        s_valid_i = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0 && !m_valid_o) break;
            @(posedge clk_i);
            #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_table(input string tag);
        int base;
        base = log_q.size();
        foreach (tbl[i]) drive_beat(tbl[i].sof, tbl[i].eol, tbl[i].hi, tbl[i].lo);
        drain();
        check({tag, "_count"}, 32'(log_q.size() - base), 32'd16);
        if (log_q.size() - base >= 16) begin
            foreach (tbl[i]) begin
                check({tag, "_lo"}, pack(log_q[base + 2*i]),
                      pack(mk(tbl[i].lo, tbl[i].band_lo, tbl[i].x, tbl[i].y, tbl[i].sof, 1'b0)));
                check({tag, "_hi"}, pack(log_q[base + 2*i + 1]),
                      pack(mk(tbl[i].hi, tbl[i].band_lo + 2'd1, tbl[i].x, tbl[i].y, 1'b0, tbl[i].eol)));
            end
            if (tag == "cont")
                check("cont_no_gaps", 32'(log_q[base + 15].cyc - log_q[base].cyc), 32'd15);
        end
    endtask

    initial begin
        int   base;
        int   exp_x [5] = '{0, 1, 2, 3, 3};
        bit   sof, eol;

        //            sof eol  hi        lo        band  x     y
        tbl[0] = '{1'b1, 1'b0, 16'hA001, 16'h5001, 2'd0, 2'd0, 2'd0};
        tbl[1] = '{1'b0, 1'b1, 16'hA002, 16'h5002, 2'd0, 2'd1, 2'd0};
        tbl[2] = '{1'b0, 1'b0, 16'hA003, 16'h5003, 2'd2, 2'd0, 2'd0};
        tbl[3] = '{1'b0, 1'b1, 16'hA004, 16'h5004, 2'd2, 2'd1, 2'd0};
        tbl[4] = '{1'b0, 1'b0, 16'hA005, 16'h5005, 2'd0, 2'd0, 2'd1};
        tbl[5] = '{1'b0, 1'b1, 16'hA006, 16'h5006, 2'd0, 2'd1, 2'd1};
        tbl[6] = '{1'b0, 1'b0, 16'hA007, 16'h5007, 2'd2, 2'd0, 2'd1};
        tbl[7] = '{1'b0, 1'b1, 16'hA008, 16'h5008, 2'd2, 2'd1, 2'd1};

        model_reset();
        rst_i     = 1'b1;
        s_valid_i = 1'b0;
        s_sof_i   = 1'b0;
        s_eol_i   = 1'b0;
        s_data_i  = '0;
        m_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid",    32'(m_valid_o), 32'd0);
        check("rst_tags",     pack(mk(m_data_o, m_band_o, m_x_o, m_y_o, m_sof_o, m_eol_o)), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        check("rst_ready",    32'(s_ready_o), 32'd1);
        rst_i = 1'b0;
        idle(2);

        // Single-beat line: sof on low, eol on high.
        base = log_q.size();
        drive_beat(1'b1, 1'b1, 16'h0222, 16'h0111);
        @(negedge clk_i);
        check("ready_low_in_LOW", 32'(s_ready_o), 32'd0);
        check("valid_in_LOW",     32'(m_valid_o), 32'd1);
        @(posedge clk_i);
        #1;
        drain();
        check("single_count", 32'(log_q.size() - base), 32'd2);
        if (log_q.size() - base >= 2) begin
            check("single_lo", pack(log_q[base]),     pack(mk(16'h0111, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0)));
            check("single_hi", pack(log_q[base + 1]), pack(mk(16'h0222, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1)));
        end

        // Four lines of two beats, continuous, then with ready toggling 1,0,0,1.
        apply_table("cont");
        idle(2);
        rdy_mode = 1;
        apply_table("stall");
        idle(2);

        // Mid-frame sof after three beats of a vertical-high line.
        base = log_q.size();
        drive_beat(1'b1, 1'b1, 16'h1102, 16'h1101);
        drive_beat(1'b0, 1'b0, 16'h1202, 16'h1201);
        drive_beat(1'b0, 1'b0, 16'h1302, 16'h1301);
        drive_beat(1'b0, 1'b0, 16'h1402, 16'h1401);
        drive_beat(1'b1, 1'b0, 16'h1502, 16'h1501);
        drain();
        if (log_q.size() - base >= 10) begin
            check("midsof_before", pack(log_q[base + 6]), pack(mk(16'h1401, 2'd2, 2'd2, 2'd0, 1'b0, 1'b0)));
            check("midsof_restart", pack(log_q[base + 8]), pack(mk(16'h1501, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0)));
        end else begin
            check("midsof_count", 32'(log_q.size() - base), 32'd10);
        end

        // Over-long line: x saturates at 3 and overflow sticks until next sof.
        base = log_q.size();
        drive_beat(1'b1, 1'b0, 16'h2000, 16'h2100);
        for (int i = 1; i < 5; i++) drive_beat(1'b0, 1'b0, 16'(16'h2000 + i), 16'(16'h2100 + i));
        drain();
        if (log_q.size() - base >= 10) begin
            for (int i = 0; i < 5; i++) check("ovf_x", 32'(log_q[base + 2*i].x), 32'(exp_x[i]));
        end else begin
            check("ovf_count", 32'(log_q.size() - base), 32'd10);
        end
        check("ovf_set", 32'(overflow_o), 32'd1);
        drive_beat(1'b0, 1'b1, 16'h2200, 16'h2201);
        drain();
        check("ovf_sticky", 32'(overflow_o), 32'd1);
        drive_beat(1'b1, 1'b1, 16'h2300, 16'h2301);
        drain();
        check("ovf_cleared", 32'(overflow_o), 32'd0);

        // Reset while LOW holds a high word.
        rdy_mode = 3;
        idle(2);
        drive_beat(1'b1, 1'b0, 16'hDEAD, 16'hBEEF);
        rst_i     = 1'b1;
        s_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("midrst_valid", 32'(m_valid_o), 32'd0);
        check("midrst_data",  32'(m_data_o),  32'd0);
        rst_i = 1'b0;
        exp_q.delete();
        model_reset();
        base = log_q.size();
        rdy_mode = 0;
        idle(6);
        check("midrst_no_emit", 32'(log_q.size() - base), 32'd0);

        // Randomized stream against the model.
        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            sof = (i == 0) || ($urandom_range(0, 19) == 0);
            eol = ($urandom_range(0, 2) == 0);
            drive_beat(sof, eol, 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();
        check("rand_overflow", 32'(overflow_o), 32'(movf));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
